// File: rtl/cpu_pkg.sv
// Shared CPU constants and enums for the fetch-stage PC unit.
// Holds the memory map limits, the PC unit state type and the next-PC select codes.
package cpu_pkg;

  localparam logic [31:0] RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
  localparam logic [31:0] IM_LO      = 32'h0000_3000;
  localparam logic [31:0] IM_HI      = 32'h0000_6FFF;

  typedef enum logic {
    RUN,
    GUARD
  } pc_state_e;

  typedef enum logic [2:0] {
    EXC,
    ERET,
    SEQ,
    HOLD,
    JR,
    J,
    BR
  } npc_sel_e;

  // A fetch address is illegal if it is misaligned or outside instruction memory.
  function automatic logic fetch_addr_bad(input logic [31:0] addr);
    return (addr[1:0] != 2'b00) || (addr < IM_LO) || (addr > IM_HI);
  endfunction

endpackage

// File: rtl/npc_calc.sv
// Combinational branch and jump target generation from the ID-stage instruction fields.
// All sums wrap modulo 2^32.
module npc_calc (
  input  logic [31:0] id_pc,
  input  logic [15:0] id_imm16,
  input  logic [25:0] id_index,
  output logic [31:0] id_seq,
  output logic [31:0] br_target,
  output logic [31:0] j_target
);

  assign id_seq    = id_pc + 32'd4;
  assign br_target = id_seq + {{14{id_imm16[15]}}, id_imm16, 2'b00};
  assign j_target  = {id_seq[31:28], id_index, 2'b00};

endmodule

// File: rtl/npc_pc_unit.sv
// Fetch-stage program counter with prioritised next-PC selection.
// A one-cycle GUARD state follows every exception/eret redirect while ID holds a bubble.
module npc_pc_unit
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] id_pc,
  input  logic        id_branch,
  input  logic        cmp_result,
  input  logic [15:0] id_imm16,
  input  logic        id_j,
  input  logic [25:0] id_index,
  input  logic        id_jr,
  input  logic [31:0] id_rs,
  input  logic        exc_req,
  input  logic        eret,
  input  logic [31:0] epc,
  output logic [31:0] pc,
  output logic        pc_adel,
  output logic        f_bd
);

  pc_state_e   state, state_next;
  npc_sel_e    sel;
  logic [31:0] pc_next;
  logic        bd_next;
  logic [31:0] pc_seq;
  logic [31:0] id_seq;
  logic [31:0] br_target;
  logic [31:0] j_target;
  logic        id_ctl;

  npc_calc u_npc_calc (
    .id_pc     (id_pc),
    .id_imm16  (id_imm16),
    .id_index  (id_index),
    .id_seq    (id_seq),
    .br_target (br_target),
    .j_target  (j_target)
  );

  assign pc_seq = pc + 32'd4;
  assign id_ctl = id_branch | id_j | id_jr;

  always_comb begin
    if (exc_req)                     sel = EXC;
    else if (eret)                   sel = ERET;
    else if (state == GUARD)         sel = SEQ;
    else if (stall)                  sel = HOLD;
    else if (id_jr)                  sel = JR;
    else if (id_j)                   sel = J;
    else if (id_branch & cmp_result) sel = BR;
    else                             sel = SEQ;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    pc_next    = pc_seq;
    bd_next    = (state == RUN) & id_ctl;
    state_next = RUN;
    case (sel)
      EXC: begin
        pc_next    = HANDLER_PC;
        bd_next    = 1'b0;
        state_next = GUARD;
      end
      ERET: begin
        pc_next    = epc;
        bd_next    = 1'b0;
        state_next = GUARD;
      end
      HOLD: begin
        pc_next = pc;
        bd_next = f_bd;
      end
      JR:      pc_next = id_rs;
      J:       pc_next = j_target;
      BR:      pc_next = br_target;
      default: pc_next = pc_seq;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc    <= RESET_PC;
      f_bd  <= 1'b0;
      state <= RUN;
    end else begin
      pc    <= pc_next;
      f_bd  <= bd_next;
      state <= state_next;
    end
  end

  assign pc_adel = fetch_addr_bad(pc);

endmodule

// File: tb/tb_npc_pc_unit.sv
// Self-checking bench for npc_pc_unit: directed scenarios followed by randomized
// stimulus compared against a behavioural next-PC model.
module tb_npc_pc_unit;

  localparam logic [31:0] RST_PC  = 32'h0000_3000;
  localparam logic [31:0] HND_PC  = 32'h0000_4180;
  localparam logic [31:0] LO_ADDR = 32'h0000_3000;
  localparam logic [31:0] HI_ADDR = 32'h0000_6FFF;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [31:0] id_pc;
  logic        id_branch;
  logic        cmp_result;
  logic [15:0] id_imm16;
  logic        id_j;
  logic [25:0] id_index;
  logic        id_jr;
  logic [31:0] id_rs;
  logic        exc_req;
  logic        eret;
  logic [31:0] epc;
  logic [31:0] pc;
  logic        pc_adel;
  logic        f_bd;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: fetch address, delay-slot flag, and whether the next cycle is a post-redirect bubble.
  logic [31:0] m_pc;
  logic        m_bd;
  logic        m_bubble;

  always #5 clk = ~clk;

  npc_pc_unit dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .id_pc      (id_pc),
    .id_branch  (id_branch),
    .cmp_result (cmp_result),
    .id_imm16   (id_imm16),
    .id_j       (id_j),
    .id_index   (id_index),
    .id_jr      (id_jr),
    .id_rs      (id_rs),
    .exc_req    (exc_req),
    .eret       (eret),
    .epc        (epc),
    .pc         (pc),
    .pc_adel    (pc_adel),
    .f_bd       (f_bd)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic model_adel(input logic [31:0] a);
    return (a % 4 != 0) || (a < LO_ADDR) || (a > HI_ADDR);
  endfunction

  task automatic idle();
    stall = 0; id_pc = RST_PC; id_branch = 0; cmp_result = 0; id_imm16 = '0;
    id_j = 0; id_index = '0; id_jr = 0; id_rs = '0; exc_req = 0; eret = 0; epc = '0;
  endtask

  task automatic model_reset();
    m_pc = RST_PC; m_bd = 0; m_bubble = 0;
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".pc"}, pc, m_pc);
    check({tag, ".bd"}, 32'(f_bd), 32'(m_bd));
    check({tag, ".adel"}, 32'(pc_adel), 32'(model_adel(m_pc)));
  endtask

  // Advance the model by one clock using the inputs currently driven, then clock the DUT and compare.
  task automatic step(input string tag);
    int          off;
    logic [31:0] link;
    off  = int'($signed(id_imm16));
    link = id_pc + 32'd4;
    if (reset) begin
      model_reset();
    end else if (exc_req) begin
      m_pc = HND_PC; m_bd = 0; m_bubble = 1;
    end else if (eret) begin
      m_pc = epc; m_bd = 0; m_bubble = 1;
    end else if (m_bubble) begin
      m_pc = m_pc + 4; m_bd = 0; m_bubble = 0;
    end else if (stall) begin
      m_bubble = 0;
    end else begin
      m_bd = id_branch | id_j | id_jr;
      if (id_jr)                       m_pc = id_rs;
      else if (id_j)                   m_pc = (link & 32'hF000_0000) | (32'(id_index) * 4);
      else if (id_branch && cmp_result) m_pc = link + 32'(off * 4);
      else                             m_pc = m_pc + 4;
      m_bubble = 0;
    end
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  initial begin
    idle();
    reset = 1;
    model_reset();
    #12;
    compare_all("reset");
    @(negedge clk);
    reset = 0;
    #1;

    // Sequential fetch after reset release.
    step("seq1"); check("seq1.lit", pc, 32'h3004);
    step("seq2"); check("seq2.lit", pc, 32'h3008);

    // Backward branch taken, then not taken; both mark a delay slot.
    id_pc = 32'h3010; id_branch = 1; cmp_result = 1; id_imm16 = 16'hFFFC;
    step("br_taken"); check("br_taken.lit", pc, 32'h3004); check("br_taken.bd", 32'(f_bd), 1);
    cmp_result = 0;
    step("br_not"); check("br_not.lit", pc, 32'h3008); check("br_not.bd", 32'(f_bd), 1);

    // Register jumps to misaligned and out-of-range addresses.
    idle(); id_jr = 1; id_rs = 32'h3002;
    step("jr_mis"); check("jr_mis.adel", 32'(pc_adel), 1);
    id_rs = 32'h7000;
    step("jr_hi"); check("jr_hi.adel", 32'(pc_adel), 1);

    // Stall with a pending jump holds pc; an exception inside the stall still wins.
    idle(); id_pc = 32'h3100; id_j = 1; id_index = 26'h0000C40; stall = 1;
    for (int i = 0; i < 3; i++) begin
      step("stall"); check("stall.hold", pc, 32'h7000);
    end
    exc_req = 1;
    step("exc_stall"); check("exc_stall.lit", pc, HND_PC); check("exc_stall.bd", 32'(f_bd), 0);

    // eret in the bubble cycle, branch controls present and ignored.
    idle(); eret = 1; epc = 32'h3020; id_pc = 32'h3040; id_branch = 1; cmp_result = 1; id_imm16 = 16'h0010;
    step("eret"); check("eret.lit", pc, 32'h3020);
    eret = 0;
    step("guard"); check("guard.lit", pc, 32'h3024); check("guard.bd", 32'(f_bd), 0);
    step("resume"); check("resume.lit", pc, 32'h3084);

    // Asynchronous reset between edges while pc is 0x4184.
    idle(); exc_req = 1;
    step("exc2");
    exc_req = 0;
    step("h4"); check("h4.lit", pc, 32'h4184);
    #2;
    reset = 1;
    #1;
    model_reset();
    check("async_rst.pc", pc, RST_PC);
    check("async_rst.bd", 32'(f_bd), 0);
    @(negedge clk);
    reset = 0;
    #1;

    // Randomized traffic with occasional mid-cycle resets.
    for (int n = 0; n < 600; n++) begin
      int r;
      idle();
      id_pc    = LO_ADDR + 32'($urandom_range(0, 4095) * 4);
      id_imm16 = 16'($urandom);
      id_index = 26'($urandom);
      id_rs    = ($urandom_range(0, 7) == 0) ? $urandom : LO_ADDR + 32'($urandom_range(0, 4095) * 4);
      epc      = LO_ADDR + 32'($urandom_range(0, 4095) * 4);
      cmp_result = 1'($urandom);
      r = int'($urandom_range(0, 9));
      case (r)
        3, 4: id_branch = 1;
        5:    id_j = 1;
        6:    id_jr = 1;
        7: begin
          id_branch = 1'($urandom); id_j = 1'($urandom); id_jr = 1'($urandom);
        end
        default: ;
      endcase
      stall   = ($urandom_range(0, 4) == 0);
      exc_req = ($urandom_range(0, 11) == 0);
      eret    = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 79) == 0) begin
        #2;
        reset = 1;
        #1;
        model_reset();
        check("rnd_rst.pc", pc, RST_PC);
        step("rnd_rst_hold");
        reset = 0;
      end else begin
        step("rnd");
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/npc_pc_unit.md
# npc_pc_unit

Fetch-stage program-counter register with next-PC selection. Sits directly downstream of the ID-stage branch comparator. Consumes its one-bit taken result together with the decoded branch/jump controls and the CP0 redirect requests. Produces the fetch address for instruction memory plus the fetch-stage exception and delay-slot flags that travel into the IF/ID register.

## Interface
- RESET_PC, 32'h0000_3000: PC value loaded on reset.
- HANDLER_PC, 32'h0000_4180: exception entry address.
- IM_LO, 32'h0000_3000: lowest legal fetch address.
- IM_HI, 32'h0000_6FFF: highest legal fetch byte address.

Ports (name, direction, width, meaning):
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  hazard stall from the hazard unit; hold PC.
- id_pc  in  32  PC of the instruction currently in ID.
- id_branch  in  1  ID instruction is a conditional branch.
- cmp_result  in  1  taken result from the branch comparator.
- id_imm16  in  16  branch offset field.
- id_j  in  1  ID instruction is j/jal.
- id_index  in  26  jump instr_index field.
- id_jr  in  1  ID instruction is jr/jalr.
- id_rs  in  32  forwarded rs value for jr/jalr.
- exc_req  in  1  CP0 exception/interrupt taken this cycle.
- eret  in  1  eret committing this cycle.
- epc  in  32  CP0 EPC value.
- pc  out  32  current fetch address.
- pc_adel  out  1  fetch address error for current pc.
- f_bd  out  1  instruction at pc is a branch delay slot.

## Operation
- Next-PC priority, highest first:
  1. exc_req → HANDLER_PC
  2. eret → epc
  3. guard → pc+4 (see below)
  4. stall → hold
  5. id_jr → id_rs
  6. id_j → {id_pc+4[31:28], id_index, 2'b00}
  7. id_branch & cmp_result → id_pc + 4 + (sext(id_imm16) << 2)
  8. default → pc+4
- Branch arithmetic is 32-bit modulo 2^32; wrap-around is not flagged here.
- The only legal control combinations are one-hot or zero among id_branch, id_j and id_jr. Other combinations follow the priority order above.
- State machine, 2 states:
  - RUN: normal priority selection.
  - GUARD: entered on the edge where exc_req or eret redirects. Lasts exactly one cycle. In GUARD the ID slot holds a flushed bubble, so id_branch, id_j, id_jr and stall are ignored and next pc = pc+4. exc_req and eret are still honoured in GUARD and re-enter GUARD. Otherwise the unit returns to RUN.
- f_bd is a registered flag, set on an edge where PC advances (not stalled, not redirected by exc_req or eret) and id_branch, id_j or id_jr was asserted. Otherwise it is cleared on any advance, and it holds during stall.
- pc_adel = (pc[1:0] != 0) | (pc < IM_LO) | (pc > IM_HI), computed combinationally from pc. The bad address is still presented; downstream converts it to an AdEL fault.

## Timing
- Reset (asynchronous, immediate):
  - pc = RESET_PC
  - f_bd = 0
  - state = RUN
  - pc_adel = 0, since RESET_PC is legal.
- All redirects take effect on the next rising edge; pc is valid one cycle after the decision inputs. There is zero combinational path from inputs to pc.
- A stall holds pc and f_bd for as many cycles as asserted. Control inputs are re-sampled when stall drops.
- exc_req together with stall: exc_req wins, pc = HANDLER_PC next cycle, f_bd = 0.
- exc_req together with eret: exc_req wins.
- Reset asserted mid-GUARD or mid-stall forces the reset values at once. After release, operation starts in RUN.

## Structure
- Shared package cpu_pkg holds:
  - constants RESET_PC, HANDLER_PC, IM_LO, IM_HI
  - the state enum RUN/GUARD
  - the next-PC select enum (EXC, ERET, SEQ, HOLD, JR, J, BR)
- One combinational sub-module, npc_calc, produces the branch, jump and sequential targets from id_pc, id_imm16 and id_index. The register, state machine and priority mux stay in the top.

## Test plan
- Reset release with no controls → pc = 0x3000, 0x3004, 0x3008 on successive edges; f_bd = 0; pc_adel = 0.
- id_pc = 0x3010, id_branch = 1, cmp_result = 1, imm16 = 0xFFFC → next pc = 0x3004 and f_bd = 1. The same case with cmp_result = 0 → pc+4 and f_bd = 1.
- id_jr = 1, id_rs = 0x3002 → pc = 0x3002, pc_adel = 1. id_rs = 0x7000 → pc_adel = 1.
- stall held for 3 cycles with id_j = 1 → pc is constant. Then exc_req pulses during the stall → pc = 0x4180 next edge, f_bd = 0, state = GUARD.
- eret with epc = 0x3020 and id_branch = 1, cmp_result = 1 asserted in the following GUARD cycle → pc = 0x3020, then 0x3024 (branch ignored), then normal operation resumes.
- Reset asserted asynchronously between edges while pc = 0x4184 → pc reads 0x3000 before the next clock edge.
